// File: rtl/student_fir_out_combiner.sv
// student_fir_out_combiner
// Gathers one result per FIR lane into a frame, sums the lanes serially,
// then rounds, shifts and saturates the sum into one output sample.
//
// Ports:
//   clk_i           clock
//   rst_ni          asynchronous active-low reset
//   valid_strobe_i  per-lane one-cycle result strobe
//   y_i             per-lane results, lane k at [k*DATA_SIZE_FIR_OUT +: DATA_SIZE_FIR_OUT]
//   clear_i         one-cycle pulse clearing the sticky flags
//   sample_o        combined output sample, held until the next frame
//   valid_strobe_o  one-cycle pulse marking a new sample_o
//   busy_o          high while the frame is being accumulated/rounded/emitted
//   overrun_o       sticky: a lane strobed twice within one frame
//   timeout_o       sticky: a frame was closed by the timeout
//   state_o         debug view of the FSM state (state_t encoding)
//
// Handshake: there is no backpressure. Each strobe (input or output) is a
// single-cycle qualifier; the data beside it is valid only in that cycle and
// the receiver must take it on that edge.

module student_fir_out_combiner #(
  parameter int NUM_FIR           = 4,
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int SHIFT             = 15,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_FIR-1:0]                     valid_strobe_i,
  input  logic [NUM_FIR*DATA_SIZE_FIR_OUT-1:0]   y_i,
  input  logic                                   clear_i,
  output logic [DATA_SIZE-1:0]                   sample_o,
  output logic                                   valid_strobe_o,
  output logic                                   busy_o,
  output logic                                   overrun_o,
  output logic                                   timeout_o,
  output logic [2:0]                             state_o
);

  localparam int YW     = DATA_SIZE_FIR_OUT;
  // One extra bit on top of the lane growth leaves room for the rounding add.
  localparam int SUM_W  = YW + $clog2(NUM_FIR) + 1;
  localparam int IDX_W  = (NUM_FIR > 1) ? $clog2(NUM_FIR) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1) > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_FIR - 1);
  localparam logic [CNT_W-1:0]        TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic signed [SUM_W-1:0] RND      = (SHIFT > 0) ? (SUM_W'(1) << RND_POS) : '0;
  localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ACCUM   = 3'd2,
    S_ROUND   = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [YW-1:0]           cap_q  [NUM_FIR];
  logic [YW-1:0]           work_q [NUM_FIR];
  logic [NUM_FIR-1:0]      got_q;
  logic signed [SUM_W-1:0] acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_SIZE-1:0]    sample_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic                    timeout_q;

  logic                    snap;
  logic                    timeout_hit;
  logic                    overrun_set;
  logic signed [SUM_W-1:0] rounded;
  logic [DATA_SIZE-1:0]    sat;

  // Next-state logic. IDLE also checks for a complete frame so that lanes
  // arriving together go straight to ACCUM on the following edge.
  always_comb begin
    state_d     = state_q;
    snap        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (&got_q) begin
          state_d = S_ACCUM;
          snap    = 1'b1;
        end else if (|got_q) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (&got_q) begin
          state_d = S_ACCUM;
          snap    = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d     = S_ACCUM;
          snap        = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      S_ACCUM: begin
        if (idx_q == LAST_IDX) state_d = S_ROUND;
      end
      S_ROUND: state_d = S_OUT;
      S_OUT:   state_d = (|got_q) ? S_COLLECT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // On the snapshot edge got is being handed over to the next frame, so a
  // strobe there is a first arrival, not a repeat.
  assign overrun_set = (|(valid_strobe_i & got_q)) && !snap;

  always_comb begin
    rounded = (acc_q + RND) >>> SHIFT;
    if (rounded > SAT_MAX)      sat = SAT_MAX[DATA_SIZE-1:0];
    else if (rounded < SAT_MIN) sat = SAT_MIN[DATA_SIZE-1:0];
    else                        sat = rounded[DATA_SIZE-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lane capture and frame snapshot. Missing lanes contribute zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      got_q <= '0;
      for (int k = 0; k < NUM_FIR; k++) begin
        cap_q[k]  <= '0;
        work_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FIR; k++) begin
        if (snap) begin
          work_q[k] <= got_q[k] ? cap_q[k] : '0;
          got_q[k]  <= valid_strobe_i[k];
        end else if (valid_strobe_i[k]) begin
          got_q[k] <= 1'b1;
        end
        if (valid_strobe_i[k]) cap_q[k] <= y_i[k*YW +: YW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_d == S_COLLECT && state_q != S_COLLECT) begin
      cnt_q <= '0;
    end else if (state_q == S_COLLECT && TIMEOUT_CYCLES != 0) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (snap) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (state_q == S_ACCUM) begin
      acc_q <= acc_q + SUM_W'($signed(work_q[idx_q]));
      idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= (state_q == S_ROUND);
      if (state_q == S_ROUND) sample_q <= sat;
      // A set event in the same cycle as clear_i wins.
      if (overrun_set)  overrun_q <= 1'b1;
      else if (clear_i) overrun_q <= 1'b0;
      if (timeout_hit)  timeout_q <= 1'b1;
      else if (clear_i) timeout_q <= 1'b0;
    end
  end

  assign sample_o       = sample_q;
  assign valid_strobe_o = valid_q;
  assign busy_o         = (state_q == S_ACCUM) || (state_q == S_ROUND) || (state_q == S_OUT);
  assign overrun_o      = overrun_q;
  assign timeout_o      = timeout_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_student_fir_out_combiner.sv
// Directed testbench for student_fir_out_combiner (default parameters).
module tb_student_fir_out_combiner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   valid_strobe_i = '0;
  logic [127:0] y_i = '0;
  logic         clear_i = 1'b0;
  logic [15:0]  sample_o;
  logic         valid_strobe_o;
  logic         busy_o;
  logic         overrun_o;
  logic         timeout_o;
  logic [2:0]   state_o;

  int tests_run = 0;
  int fails = 0;
  int stray = 0;

  student_fir_out_combiner dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_strobe_i (valid_strobe_i),
    .y_i            (y_i),
    .clear_i        (clear_i),
    .sample_o       (sample_o),
    .valid_strobe_o (valid_strobe_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o),
    .state_o        (state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // All driving and sampling happens on the falling edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (valid_strobe_o) stray++;
    end
  endtask

  task automatic pulse(input logic [3:0] lanes, input logic [31:0] v0, v1, v2, v3);
    valid_strobe_i = lanes;
    y_i = {v3, v2, v1, v0};
    @(negedge clk);
    if (valid_strobe_o) stray++;
    valid_strobe_i = '0;
    y_i = '0;
    clear_i = 1'b0;
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  // Observes the output for a bounded number of cycles.
  task automatic watch(input int cycles, output int first_n, output int cnt,
                       output logic [15:0] smp, output logic busy1);
    first_n = -1; cnt = 0; smp = '0; busy1 = 1'b0;
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = busy_o;
      if (valid_strobe_o) begin
        cnt++;
        if (first_n < 0) begin
          first_n = n;
          smp = sample_o;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(3);
    tests_run++;
    if ({sample_o, valid_strobe_o, busy_o, overrun_o, timeout_o} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: got sample=%h v=%b b=%b o=%b t=%b, want all 0",
               sample_o, valid_strobe_o, busy_o, overrun_o, timeout_o);
    end
    rst_n = 1'b1;
    idle(3);
    tests_run++;
    if (stray !== 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: strobes=%0d busy=%b, want 0 and 0", stray, busy_o);
    end
  endtask

  task automatic test_basic();
    int f, c; logic [15:0] s; logic b1;
    pulse(4'hF, 32'h4000, 32'h4000, 32'h4000, 32'h4000);
    watch(10, f, c, s, b1);
    tests_run++;
    if (f !== 6 || c !== 1) begin
      fails++;
      $display("FAIL basic_latency: first=%0d count=%0d, want 6 and 1", f, c);
    end
    tests_run++;
    if (s !== 16'h0002) begin
      fails++;
      $display("FAIL basic_sample: got %h, want 0002", s);
    end
    tests_run++;
    if (b1 !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b, want 1 in ACCUM", b1);
    end
    tests_run++;
    if (overrun_o !== 1'b0 || timeout_o !== 1'b0 || sample_o !== 16'h0002) begin
      fails++;
      $display("FAIL basic_flags_hold: o=%b t=%b sample=%h, want 0 0 0002",
               overrun_o, timeout_o, sample_o);
    end
  endtask

  task automatic test_round_sat();
    int f, c; logic [15:0] s; logic b1;
    logic [31:0] vals [3] = '{32'h0, 32'h40000000, 32'hC0000000};
    logic [15:0] exps [3] = '{16'h0001, 16'h7FFF, 16'h8000};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) pulse(4'hF, 32'h4000, 32'h0, 32'h0, 32'h0);
      else        pulse(4'hF, vals[i], vals[i], vals[i], vals[i]);
      watch(10, f, c, s, b1);
      tests_run++;
      if (f !== 6 || c !== 1 || s !== exps[i]) begin
        fails++;
        $display("FAIL round_sat[%0d]: first=%0d count=%0d sample=%h, want 6 1 %h",
                 i, f, c, s, exps[i]);
      end
    end
  endtask

  task automatic test_stagger();
    int f, c; logic [15:0] s; logic b1; int st0;
    st0 = stray;
    pulse(4'b0001, 32'h8000, 32'h0, 32'h0, 32'h0);
    idle(2);
    pulse(4'b0010, 32'h0, 32'h8000, 32'h0, 32'h0);
    idle(3);
    pulse(4'b0100, 32'h0, 32'h0, 32'h8000, 32'h0);
    idle(2);
    pulse(4'b1000, 32'h0, 32'h0, 32'h0, 32'h8000);
    watch(12, f, c, s, b1);
    tests_run++;
    if (stray !== st0 || f !== 6 || c !== 1 || s !== 16'h0004) begin
      fails++;
      $display("FAIL stagger: early=%0d first=%0d count=%0d sample=%h, want 0 6 1 0004",
               stray - st0, f, c, s);
    end
  endtask

  task automatic test_timeout();
    int f, c; logic [15:0] s; logic b1;
    pulse(4'b0011, 32'h8000, 32'h8000, 32'h0, 32'h0);
    watch(80, f, c, s, b1);
    tests_run++;
    if (f !== 70 || c !== 1 || s !== 16'h0002) begin
      fails++;
      $display("FAIL timeout_frame: first=%0d count=%0d sample=%h, want 70 1 0002", f, c, s);
    end
    tests_run++;
    if (timeout_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_flag: got %b, want 1", timeout_o);
    end
    clear_pulse();
    tests_run++;
    if (timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: got %b, want 0", timeout_o);
    end
  endtask

  task automatic test_overrun();
    int f, c; logic [15:0] s; logic b1;
    pulse(4'b0100, 32'h0, 32'h0, 32'h8000, 32'h0);
    clear_i = 1'b1;  // clear coincides with the overrun set: set wins
    pulse(4'b0100, 32'h0, 32'h0, 32'h10000, 32'h0);
    tests_run++;
    if (overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set_wins: got %b, want 1", overrun_o);
    end
    pulse(4'b1011, 32'h0, 32'h0, 32'h0, 32'h0);
    watch(10, f, c, s, b1);
    tests_run++;
    if (f !== 6 || c !== 1 || s !== 16'h0002 || overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_frame: first=%0d count=%0d sample=%h ovr=%b, want 6 1 0002 1",
               f, c, s, overrun_o);
    end
    clear_pulse();
    tests_run++;
    if (overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b, want 0", overrun_o);
    end
    // Lane 0 strobes again on the ACCUM-entry edge: belongs to the next frame.
    pulse(4'hF, 32'h4000, 32'h4000, 32'h4000, 32'h4000);
    pulse(4'b0001, 32'h8000, 32'h0, 32'h0, 32'h0);
    watch(10, f, c, s, b1);
    tests_run++;
    if (f !== 5 || c !== 1 || s !== 16'h0002 || overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL entry_edge_frame: first=%0d count=%0d sample=%h ovr=%b, want 5 1 0002 0",
               f, c, s, overrun_o);
    end
    pulse(4'b1110, 32'h0, 32'h8000, 32'h8000, 32'h8000);
    watch(10, f, c, s, b1);
    tests_run++;
    if (f !== 6 || c !== 1 || s !== 16'h0004 || overrun_o !== 1'b0 || timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL entry_edge_next: first=%0d count=%0d sample=%h ovr=%b to=%b, want 6 1 0004 0 0",
               f, c, s, overrun_o, timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    int f, c; logic [15:0] s; logic b1;
    pulse(4'b0001, 32'h100, 32'h0, 32'h0, 32'h0);
    pulse(4'b0001, 32'h200, 32'h0, 32'h0, 32'h0);
    pulse(4'b1110, 32'h0, 32'hC0000000, 32'hC0000000, 32'hC0000000);
    idle(2);
    tests_run++;
    if (busy_o !== 1'b1 || overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: busy=%b ovr=%b, want 1 1", busy_o, overrun_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sample_o, valid_strobe_o, busy_o, overrun_o, timeout_o} !== 20'h0) begin
      fails++;
      $display("FAIL async_reset: sample=%h v=%b b=%b o=%b t=%b, want all 0",
               sample_o, valid_strobe_o, busy_o, overrun_o, timeout_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch(20, f, c, s, b1);
    tests_run++;
    if (c !== 0) begin
      fails++;
      $display("FAIL post_reset_quiet: strobes=%0d, want 0", c);
    end
    pulse(4'hF, 32'h4000, 32'h4000, 32'h4000, 32'h4000);
    watch(10, f, c, s, b1);
    tests_run++;
    if (f !== 6 || c !== 1 || s !== 16'h0002) begin
      fails++;
      $display("FAIL post_reset_frame: first=%0d count=%0d sample=%h, want 6 1 0002", f, c, s);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_round_sat();
    test_stagger();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/student_fir_out_combiner.md
Name: student_fir_out_combiner

Overview:
Collects the per-stage results of NUM_FIR parallel FIR stages (y + one-cycle valid strobe per stage) into one output frame. Sums them with a sequential accumulator, then rounds, scales and saturates the sum to a DATA_SIZE output sample. It emits that sample with a one-cycle valid strobe to the audio output path. It sits between the FIR array and the DAC/output sample interface, and is the consumer end of the FIR result interface.

Parameters:
NUM_FIR, 4, number of FIR stages/lanes (>=1)
DATA_SIZE, 16, output sample width
DATA_SIZE_FIR_OUT, 32, width of each lane result (two's complement)
SHIFT, 15, arithmetic right shift applied to the sum (0..DATA_SIZE_FIR_OUT)
TIMEOUT_CYCLES, 64, cycles to wait in COLLECT for missing lanes; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
valid_strobe_i  in  NUM_FIR  per-lane result strobe, one-cycle pulse
y_i  in  NUM_FIR x DATA_SIZE_FIR_OUT  per-lane result; valid only in the strobe cycle
clear_i  in  1  one-cycle pulse; clears the sticky flags
sample_o  out  DATA_SIZE  combined output sample
valid_strobe_o  out  1  one-cycle pulse; sample_o is new
busy_o  out  1  high in ACCUM/ROUND/OUT
overrun_o  out  1  sticky: a lane strobed twice within one frame
timeout_o  out  1  sticky: a frame was completed by timeout

Behaviour:
- Reset (async): all outputs 0; state IDLE; capture/work registers, got flags, accumulator and counters cleared. Reset mid-frame discards the frame; no strobe follows the reset release.
- Capture: lane k is registered on every edge where valid_strobe_i[k]=1. The edge loads cap[k]<=y_i[k] and sets got[k]. y_i is never sampled outside its strobe cycle, because the upstream stage clears y after the strobe.
- Repeat strobe on a lane with got[k] already set: overwrite cap[k] with the newer value and set overrun_o.
- SUM_W = DATA_SIZE_FIR_OUT + clog2(NUM_FIR) + 1. Every lane value is sign-extended to SUM_W. The sum never wraps.
- FSM:
  - IDLE: got==0; on any got bit -> COLLECT, timeout counter=0.
  - COLLECT: counter increments each cycle. If got all ones, or (TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1), -> ACCUM. The timeout path sets timeout_o.
  - ACCUM entry edge: snapshot work[k]=got[k]?cap[k]:0; clear got; acc=0; idx=0. A strobe on that same edge lands in the cleared got/cap and counts toward the next frame.
  - ACCUM: each cycle acc+=work[idx], idx++. After lane NUM_FIR-1 -> ROUND.
  - ROUND: r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT. Saturate r to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]. Register r into sample_o. Set valid_strobe_o=1. -> OUT.
  - OUT: valid_strobe_o=0. -> COLLECT if any got bit is set, else IDLE.
- Latency: let edge 0 be the edge that sets the last got bit. The ACCUM snapshot happens at edge 1. valid_strobe_o is high in the cycle following edge NUM_FIR+2.
- sample_o holds its value until the next frame.
- Strobes arriving during ACCUM/ROUND/OUT are captured for the next frame. They do not set overrun unless repeated.
- clear_i clears overrun_o and timeout_o. If a set event occurs in the same cycle, the set wins.
- Throughput: one frame per NUM_FIR+3 cycles minimum. The upstream sample period is always far longer.

Test Plan:
1. NUM_FIR=4, SHIFT=15; all lanes strobe in the same cycle with y=0x00004000 -> sample_o=0x0002 (65536>>15), valid_strobe_o high exactly 1 cycle, 6 cycles after the strobe edge; flags 0.
2. Rounding: y0=0x00004000, y1..3=0 -> sample_o=0x0001 (16384+16384=32768, >>15). Saturation: all y=0x40000000 -> 0x7FFF; all y=0xC0000000 -> 0x8000.
3. Staggered strobes on lanes 0,1,2,3 at cycles 0,3,7,10, each y=0x00008000 -> exactly one valid_strobe_o, 6 cycles after the lane-3 edge, sample_o=0x0004.
4. Timeout: only lanes 0,1 strobe, y=0x00008000 each, TIMEOUT_CYCLES=64 -> output after the timeout with sample_o=0x0002 and timeout_o=1. A clear_i pulse then returns timeout_o to 0.
5. Overrun: lane 2 strobes y=0x00008000 then y=0x00010000 before the other lanes complete (others 0) -> sample_o=0x0002, overrun_o=1. A strobe on the ACCUM-entry edge is counted in the next frame.
6. Assert rst_ni low mid-ACCUM -> all outputs 0 immediately (asynchronously); after release, no valid_strobe_o until a fresh complete frame arrives.
